// File: rtl/drp_reconf_seq.sv
// drp_reconf_seq: DRP master that reprograms a PLL from an (address, mask, data) table.
// It holds the PLL in reset, read-modify-writes every table entry over the DRP port,
// then releases the reset and waits for LOCKED.
//
// Ports:
//   DCLK, RST        clock; asynchronous active-high reset
//   SEN              start strobe, accepted only in IDLE
//   BUSY             high from the cycle after SEN is accepted until DONE/ERR
//   SRDY             one-cycle pulse: sequence done and PLL locked
//   ERR              sticky timeout flag, cleared by the next accepted SEN or RST
//   TBL_IDX          current table index
//   TBL_DADDR/MASK/DATA  table entry for TBL_IDX (combinational lookup)
//   DADDR, DEN, DWE, DI, DO, DRDY  DRP master interface
//   PLL_RST          PLL reset, held for the whole DRP phase
//   LOCKED           PLL lock indicator
module drp_reconf_seq #(
    parameter int unsigned ENTRIES      = 23,
    parameter int unsigned DRP_TIMEOUT  = 64,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic        DCLK,
    input  logic        RST,
    input  logic        SEN,
    output logic        BUSY,
    output logic        SRDY,
    output logic        ERR,
    output logic [6:0]  TBL_IDX,
    input  logic [6:0]  TBL_DADDR,
    input  logic [15:0] TBL_MASK,
    input  logic [15:0] TBL_DATA,
    output logic [6:0]  DADDR,
    output logic        DEN,
    output logic        DWE,
    output logic [15:0] DI,
    input  logic [15:0] DO,
    input  logic        DRDY,
    output logic        PLL_RST,
    input  logic        LOCKED
);

    localparam int unsigned IDX_W  = 7;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DCNT_W = $clog2(DRP_TIMEOUT + 1);
    localparam int unsigned LCNT_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ASSERT_RST,
        S_READ,
        S_WAIT_R,
        S_MODIFY,
        S_WRITE,
        S_WAIT_W,
        S_NEXT,
        S_RELEASE,
        S_WAIT_LOCK,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                srdy_q, srdy_d;
    logic                err_q, err_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]   daddr_q, daddr_d;
    logic                den_q, den_d;
    logic                dwe_q, dwe_d;
    logic [DATA_W-1:0]   di_q, di_d;
    logic                pll_rst_q, pll_rst_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                seen_low_q, seen_low_d;
    logic                last_q, last_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic [LCNT_W-1:0]   lcnt_q, lcnt_d;

    logic drdy_hi, drdy_lo, dcnt_sat, lcnt_sat, drp_fail;

    // X on DRDY counts as neither ready nor busy, so only the timeout can end the wait
    assign drdy_hi  = (DRDY == 1'b1);
    assign drdy_lo  = (DRDY == 1'b0);
    assign dcnt_sat = (dcnt_q == DCNT_W'(DRP_TIMEOUT));
    assign lcnt_sat = (lcnt_q == LCNT_W'(LOCK_TIMEOUT));

    // State and registered outputs
    always_ff @(posedge DCLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            srdy_q     <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            daddr_q    <= '0;
            den_q      <= 1'b0;
            dwe_q      <= 1'b0;
            di_q       <= '0;
            pll_rst_q  <= 1'b0;
            rdata_q    <= '0;
            seen_low_q <= 1'b0;
            last_q     <= 1'b0;
            dcnt_q     <= '0;
            lcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            srdy_q     <= srdy_d;
            err_q      <= err_d;
            idx_q      <= idx_d;
            daddr_q    <= daddr_d;
            den_q      <= den_d;
            dwe_q      <= dwe_d;
            di_q       <= di_d;
            pll_rst_q  <= pll_rst_d;
            rdata_q    <= rdata_d;
            seen_low_q <= seen_low_d;
            last_q     <= last_d;
            dcnt_q     <= dcnt_d;
            lcnt_q     <= lcnt_d;
        end
    end

    // Next state and next register values. DEN is launched on the edge that enters
    // READ/WRITE so the strobe lands in that state's own cycle; if DRDY is not high
    // at that edge the state waits and launches DEN later.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        srdy_d     = 1'b0;
        err_d      = err_q;
        idx_d      = idx_q;
        daddr_d    = daddr_q;
        den_d      = 1'b0;
        dwe_d      = 1'b0;
        di_d       = di_q;
        pll_rst_d  = pll_rst_q;
        rdata_d    = rdata_q;
        seen_low_d = seen_low_q;
        last_d     = last_q;
        dcnt_d     = dcnt_q;
        lcnt_d     = lcnt_q;
        drp_fail   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (SEN) begin
                    state_d   = S_ASSERT_RST;
                    idx_d     = '0;
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                    pll_rst_d = 1'b1;
                    last_d    = 1'b0;
                end
            end

            S_ASSERT_RST: begin
                state_d = S_READ;
                dcnt_d  = '0;
                if (drdy_hi) begin
                    den_d      = 1'b1;
                    daddr_d    = TBL_DADDR;
                    seen_low_d = 1'b0;
                end
            end

            S_READ: begin
                if (den_q) begin
                    state_d = S_WAIT_R;
                    dcnt_d  = dcnt_q + DCNT_W'(1);
                end else if (drdy_hi) begin
                    den_d      = 1'b1;
                    daddr_d    = TBL_DADDR;
                    seen_low_d = 1'b0;
                    dcnt_d     = '0;
                end else if (dcnt_sat) begin
                    drp_fail = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end

            S_WAIT_R: begin
                if (seen_low_q && drdy_hi) begin
                    rdata_d = DO;
                    state_d = S_MODIFY;
                end else if (dcnt_sat) begin
                    drp_fail = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                    if (drdy_lo) begin
                        seen_low_d = 1'b1;
                    end
                end
            end

            S_MODIFY: begin
                di_d    = (rdata_q & TBL_MASK) | (TBL_DATA & ~TBL_MASK);
                state_d = S_WRITE;
                dcnt_d  = '0;
                if (drdy_hi) begin
                    den_d      = 1'b1;
                    dwe_d      = 1'b1;
                    daddr_d    = TBL_DADDR;
                    seen_low_d = 1'b0;
                end
            end

            S_WRITE: begin
                if (den_q) begin
                    state_d = S_WAIT_W;
                    dcnt_d  = dcnt_q + DCNT_W'(1);
                end else if (drdy_hi) begin
                    den_d      = 1'b1;
                    dwe_d      = 1'b1;
                    daddr_d    = TBL_DADDR;
                    seen_low_d = 1'b0;
                    dcnt_d     = '0;
                end else if (dcnt_sat) begin
                    drp_fail = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end

            // Index advances on write completion so NEXT can launch the following
            // read with the new entry's address already on TBL_DADDR.
            S_WAIT_W: begin
                if (seen_low_q && drdy_hi) begin
                    state_d = S_NEXT;
                    if (idx_q == LAST_IDX) begin
                        last_d = 1'b1;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        last_d = 1'b0;
                    end
                end else if (dcnt_sat) begin
                    drp_fail = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                    if (drdy_lo) begin
                        seen_low_d = 1'b1;
                    end
                end
            end

            S_NEXT: begin
                if (last_q) begin
                    state_d   = S_RELEASE;
                    pll_rst_d = 1'b0;
                end else begin
                    state_d = S_READ;
                    dcnt_d  = '0;
                    if (drdy_hi) begin
                        den_d      = 1'b1;
                        daddr_d    = TBL_DADDR;
                        seen_low_d = 1'b0;
                    end
                end
            end

            S_RELEASE: begin
                state_d = S_WAIT_LOCK;
                lcnt_d  = '0;
            end

            S_WAIT_LOCK: begin
                if (LOCKED == 1'b1) begin
                    state_d = S_DONE;
                    srdy_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (lcnt_sat) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    lcnt_d = lcnt_q + LCNT_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A stalled DRP slave aborts the whole sequence and lets the PLL run again
        if (drp_fail) begin
            state_d   = S_IDLE;
            err_d     = 1'b1;
            busy_d    = 1'b0;
            pll_rst_d = 1'b0;
        end
    end

    assign BUSY    = busy_q;
    assign SRDY    = srdy_q;
    assign ERR     = err_q;
    assign TBL_IDX = idx_q;
    assign DADDR   = daddr_q;
    assign DEN     = den_q;
    assign DWE     = dwe_q;
    assign DI      = di_q;
    assign PLL_RST = pll_rst_q;

endmodule

// File: tb/tb_drp_reconf_seq.sv
// Bench for drp_reconf_seq: 3-entry table, DRP slave model with one low DRDY cycle,
// scoreboard queues for DRP transactions and SRDY timing.
module tb_drp_reconf_seq;

    localparam int unsigned ENTRIES = 3;
    localparam int unsigned DRP_TO  = 16;
    localparam int unsigned LOCK_TO = 40;

    typedef struct packed {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] data;
    } txn_t;

    logic        DCLK = 1'b0;
    logic        RST = 1'b1;
    logic        SEN = 1'b0;
    logic        LOCKED = 1'b1;
    logic        drdy = 1'b1;
    logic [15:0] do_r = 16'h0;
    logic        BUSY, SRDY, ERR, DEN, DWE, PLL_RST;
    logic [6:0]  TBL_IDX, DADDR;
    logic [15:0] DI;
    logic [6:0]  tbl_daddr;
    logic [15:0] tbl_mask, tbl_data;

    logic [6:0]  t_addr [3] = '{7'h28, 7'h08, 7'h4E};
    logic [15:0] t_mask [3] = '{16'hF000, 16'h00FF, 16'h0000};
    logic [15:0] t_data [3] = '{16'h0041, 16'h1234, 16'hBEEF};
    // Hand-computed: FFFF->F041, A5C3->12C3, 0000->BEEF (and idempotent on rerun)
    logic [15:0] t_wexp [3] = '{16'hF041, 16'h12C3, 16'hBEEF};

    logic [15:0] mem [128];
    logic        hang = 1'b0;

    txn_t exp_q[$];
    int   srdy_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   den_cyc = 0;
    int   err_cyc = 0;

    drp_reconf_seq #(
        .ENTRIES      (ENTRIES),
        .DRP_TIMEOUT  (DRP_TO),
        .LOCK_TIMEOUT (LOCK_TO)
    ) dut (
        .DCLK      (DCLK),
        .RST       (RST),
        .SEN       (SEN),
        .BUSY      (BUSY),
        .SRDY      (SRDY),
        .ERR       (ERR),
        .TBL_IDX   (TBL_IDX),
        .TBL_DADDR (tbl_daddr),
        .TBL_MASK  (tbl_mask),
        .TBL_DATA  (tbl_data),
        .DADDR     (DADDR),
        .DEN       (DEN),
        .DWE       (DWE),
        .DI        (DI),
        .DO        (do_r),
        .DRDY      (drdy),
        .PLL_RST   (PLL_RST),
        .LOCKED    (LOCKED)
    );

    always #5 DCLK = ~DCLK;
    always @(posedge DCLK) cyc <= cyc + 1;

    always_comb begin
        tbl_daddr = 7'h0;
        tbl_mask  = 16'h0;
        tbl_data  = 16'h0;
        if (int'(TBL_IDX) < int'(ENTRIES)) begin
            tbl_daddr = t_addr[int'(TBL_IDX)];
            tbl_mask  = t_mask[int'(TBL_IDX)];
            tbl_data  = t_data[int'(TBL_IDX)];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic txn_t mk(input logic we, input logic [6:0] a, input logic [15:0] d);
        txn_t t;
        t.we   = we;
        t.addr = a;
        t.data = d;
        return t;
    endfunction

    // DRP slave: DRDY low for one cycle after each DEN, response with DRDY's return
    initial begin : slave
        int         st;
        logic [6:0] la;
        logic       lwe;
        logic [15:0] ldi;
        st = 0; la = 7'h0; lwe = 1'b0; ldi = 16'h0;
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        mem[7'h28] = 16'hFFFF;
        mem[7'h08] = 16'hA5C3;
        forever begin
            @(negedge DCLK);
            case (st)
                0: if (DEN === 1'b1) begin
                    la = DADDR; lwe = DWE; ldi = DI; st = 1;
                end
                1: begin
                    drdy = 1'b0; st = 2;
                end
                default: if (!hang) begin
                    drdy = 1'b1;
                    if (lwe) mem[la] = ldi;
                    else do_r = mem[la];
                    st = 0;
                end
            endcase
        end
    end

    // Monitor: pops expectations whenever the DUT strobes DEN or SRDY
    initial begin : monitor
        txn_t       t;
        int         e;
        logic [6:0] prev_idx;
        logic       err_prev;
        prev_idx = 7'h0;
        err_prev = 1'b0;
        forever begin
            @(negedge DCLK);
            if (RST === 1'b0) begin
                if (DEN === 1'b1) begin
                    den_cyc = cyc;
                    chk("den_while_drdy_high", 32'(drdy), 32'd1);
                    chk("pll_rst_during_drp", 32'(PLL_RST), 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_den: got addr %0h we %0b expected no access", DADDR, DWE);
                    end else begin
                        t = exp_q.pop_front();
                        chk("txn_we", 32'(DWE), 32'(t.we));
                        chk("txn_addr", 32'(DADDR), 32'(t.addr));
                        if (t.we) chk("txn_wdata", 32'(DI), 32'(t.data));
                    end
                end
                if (SRDY === 1'b1) begin
                    if (srdy_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_srdy: got pulse at cycle %0d expected none", cyc);
                    end else begin
                        e = srdy_q.pop_front();
                        chk("srdy_cycle", 32'(cyc), 32'(e));
                    end
                end
                if (BUSY === 1'b1) begin
                    if (TBL_IDX != prev_idx) begin
                        chk("idx_step", 32'(TBL_IDX), 32'(prev_idx + 7'd1));
                        prev_idx = TBL_IDX;
                    end
                end else begin
                    prev_idx = 7'h0;
                end
                if (ERR === 1'b1 && !err_prev) err_cyc = cyc;
                err_prev = (ERR === 1'b1);
            end else begin
                err_prev = 1'b0;
                prev_idx = 7'h0;
            end
        end
    end

    task automatic push_seq();
        for (int i = 0; i < int'(ENTRIES); i++) begin
            exp_q.push_back(mk(1'b0, t_addr[i], 16'h0));
            exp_q.push_back(mk(1'b1, t_addr[i], t_wexp[i]));
        end
    endtask

    task automatic start_seq(output int k);
        @(negedge DCLK);
        SEN = 1'b1;
        k = cyc;
        @(negedge DCLK);
        SEN = 1'b0;
        chk("busy_after_sen", 32'(BUSY), 32'd1);
        chk("err_cleared_on_sen", 32'(ERR), 32'd0);
        chk("pll_rst_asserted", 32'(PLL_RST), 32'd1);
        chk("idx_start", 32'(TBL_IDX), 32'd0);
    endtask

    task automatic wait_idle(input int maxc, input string name);
        int n;
        n = 0;
        while (BUSY === 1'b1 && n < maxc) begin
            @(negedge DCLK);
            n++;
        end
        if (BUSY === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got BUSY still 1 after %0d cycles expected 0", name, maxc);
        end
        repeat (3) @(negedge DCLK);
        #1;
        chk({name, "_txn_drained"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_srdy_drained"}, 32'(srdy_q.size()), 32'd0);
        exp_q.delete();
        srdy_q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(BUSY), 32'd0);
        chk({tag, "_srdy"}, 32'(SRDY), 32'd0);
        chk({tag, "_err"}, 32'(ERR), 32'd0);
        chk({tag, "_idx"}, 32'(TBL_IDX), 32'd0);
        chk({tag, "_daddr"}, 32'(DADDR), 32'd0);
        chk({tag, "_den"}, 32'(DEN), 32'd0);
        chk({tag, "_dwe"}, 32'(DWE), 32'd0);
        chk({tag, "_di"}, 32'(DI), 32'd0);
        chk({tag, "_pll_rst"}, 32'(PLL_RST), 32'd0);
    endtask

    initial begin : main
        int  k;
        int  d;
        bit  hit;
        repeat (3) @(negedge DCLK);
        chk_reset_outputs("reset");
        RST = 1'b0;
        @(negedge DCLK);

        // Normal sequence: 3 RMWs in order, SRDY 8*3+4 cycles after SEN
        push_seq();
        start_seq(k);
        srdy_q.push_back(k + 28);
        wait_idle(200, "seq_a");
        chk("seq_a_err", 32'(ERR), 32'd0);
        chk("seq_a_pll_released", 32'(PLL_RST), 32'd0);
        chk("mem_28", 32'(mem[7'h28]), 32'h0000F041);
        chk("mem_08", 32'(mem[7'h08]), 32'h000012C3);
        chk("mem_4e", 32'(mem[7'h4E]), 32'h0000BEEF);

        // Extra SEN pulses while busy and in the DONE cycle are ignored
        push_seq();
        start_seq(k);
        srdy_q.push_back(k + 28);
        for (int c = 0; c < 40; c++) begin
            @(negedge DCLK);
            d = cyc - k;
            SEN = (d == 5 || d == 13 || d == 20 || d == 28) ? 1'b1 : 1'b0;
        end
        SEN = 1'b0;
        wait_idle(200, "seq_sen_busy");
        chk("seq_sen_busy_idle", 32'(BUSY), 32'd0);

        // Slave stalls after the first DEN: DRP timeout
        hang = 1'b1;
        exp_q.push_back(mk(1'b0, t_addr[0], 16'h0));
        start_seq(k);
        wait_idle(200, "drp_hang");
        chk("drp_hang_err", 32'(ERR), 32'd1);
        chk("drp_hang_pll_rst", 32'(PLL_RST), 32'd0);
        chk("drp_hang_busy", 32'(BUSY), 32'd0);
        d = err_cyc - den_cyc;
        chk("drp_timeout_window", 32'(d >= int'(DRP_TO) && d <= int'(DRP_TO) + 2), 32'd1);
        hang = 1'b0;
        repeat (4) @(negedge DCLK);

        // LOCKED held low: lock timeout, then a good run clears ERR
        LOCKED = 1'b0;
        push_seq();
        start_seq(k);
        wait_idle(300, "lock_to");
        chk("lock_to_err", 32'(ERR), 32'd1);
        chk("lock_to_pll_rst", 32'(PLL_RST), 32'd0);
        d = err_cyc - k;
        chk("lock_timeout_window", 32'(d >= 27 + int'(LOCK_TO) && d <= 29 + int'(LOCK_TO)), 32'd1);
        LOCKED = 1'b1;
        push_seq();
        start_seq(k);
        srdy_q.push_back(k + 28);
        wait_idle(200, "after_lock_to");
        chk("after_lock_to_err", 32'(ERR), 32'd0);

        // RST in WAIT_W of the second entry, then a clean restart from index 0
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(mk(1'b0, t_addr[i], 16'h0));
            exp_q.push_back(mk(1'b1, t_addr[i], t_wexp[i]));
        end
        start_seq(k);
        hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge DCLK);
            if (DEN === 1'b1 && DWE === 1'b1 && TBL_IDX == 7'd1) hit = 1'b1;
        end
        chk("found_wait_w_entry2", 32'(hit), 32'd1);
        @(negedge DCLK);
        RST = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        @(negedge DCLK);
        RST = 1'b0;
        repeat (3) @(negedge DCLK);
        #1;
        chk("mid_rst_txn_drained", 32'(exp_q.size()), 32'd0);
        push_seq();
        start_seq(k);
        srdy_q.push_back(k + 28);
        wait_idle(200, "restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
